// File: rtl/pulse_len_datapath.sv
// Datapath for the serial pulse-length generator: pattern detector, serial
// length capture and a down counter that shapes the output pulse.
module pulse_len_datapath #(
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PAT = 4'b1101,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serin,
  input  logic              det_en,
  input  logic              uc_en,
  input  logic              uc_set0,
  input  logic              dc_ld,
  input  logic              dc_en,
  output logic              w,
  output logic              uc_co,
  output logic              dc_co,
  output logic              pulse_out,
  output logic [DATA_W-1:0] data_q,
  output logic [DATA_W-1:0] dc_cnt
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam int UC_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);
  localparam logic [UC_W-1:0]   UC_LAST  = UC_W'(DATA_W - 1);

  logic [PAT_LEN-1:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [UC_W-1:0]    uc_cnt;
  logic               busy;

  // Pattern detector: fill guards against matching on a partly shifted history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (det_en) begin
      hist <= {hist[PAT_LEN-2:0], serin};
      if (fill != FILL_MAX)
        fill <= fill + 1'b1;
    end else begin
      hist <= '0;
      fill <= '0;
    end
  end

  // Registered-only so the controller can derive det_en from w without a loop
  assign w = (fill == FILL_MAX) && (hist == PAT);

  // Serial capture, MSB first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uc_cnt <= '0;
      data_q <= '0;
    end else if (uc_set0) begin
      uc_cnt <= '0;
      data_q <= '0;
    end else if (uc_en) begin
      data_q <= {data_q[DATA_W-2:0], serin};
      if (uc_cnt == UC_LAST)
        uc_cnt <= '0;
      else
        uc_cnt <= uc_cnt + 1'b1;
    end
  end

  assign uc_co = uc_en && (uc_cnt == UC_LAST);

  // Down counter: saturates at zero; busy keeps a stale count from pulsing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dc_cnt <= '0;
      busy   <= 1'b0;
    end else if (dc_ld) begin
      dc_cnt <= data_q;
      busy   <= 1'b1;
    end else begin
      if (dc_en && (dc_cnt != '0))
        dc_cnt <= dc_cnt - 1'b1;
      if (dc_cnt == '0)
        busy <= 1'b0;
    end
  end

  assign dc_co     = (dc_cnt == '0);
  assign pulse_out = busy && (dc_cnt != '0);

endmodule

// File: tb/tb_pulse_len_datapath.sv
// Directed self-checking bench for pulse_len_datapath with hand-computed
// expectations for detection, capture, pulse length, priorities and reset.
module tb_pulse_len_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serin = 1'b0;
  logic       det_en = 1'b0;
  logic       uc_en = 1'b0;
  logic       uc_set0 = 1'b0;
  logic       dc_ld = 1'b0;
  logic       dc_en = 1'b0;
  logic       w;
  logic       uc_co;
  logic       dc_co;
  logic       pulse_out;
  logic [3:0] data_q;
  logic [3:0] dc_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  pulse_len_datapath dut (
    .clk(clk), .rst(rst), .serin(serin), .det_en(det_en), .uc_en(uc_en),
    .uc_set0(uc_set0), .dc_ld(dc_ld), .dc_en(dc_en), .w(w), .uc_co(uc_co),
    .dc_co(dc_co), .pulse_out(pulse_out), .data_q(data_q), .dc_cnt(dc_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Land 1 ns after the rising edge; inputs change here, outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count pulse cycles and the first cycle index with dc_co high, starting
  // in the cycle right after a load edge.
  task automatic measure_pulse(input int budget, output int hi, output int first_co);
    hi = 0;
    first_co = -1;
    for (int c = 0; c < budget; c++) begin
      if (pulse_out) hi++;
      if (dc_co && first_co < 0) first_co = c;
      tick();
    end
  endtask

  task automatic capture4(input logic [3:0] bits, input string tag);
    uc_en = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      serin = bits[i];
      #1;
      check_eq($sformatf("%s_uc_co_%0d", tag, 3 - i), uc_co, (i == 0));
      tick();
    end
    uc_en = 1'b0;
    serin = 1'b0;
  endtask

  initial begin
    logic [6:0] ovl_bits;
    logic [6:0] ovl_w;
    logic [4:0] det_bits;
    int hi, first_co;

    // Reset values
    #2 rst = 1'b1;
    #5;
    check_eq("rst_w", w, 0);
    check_eq("rst_uc_co", uc_co, 0);
    check_eq("rst_dc_co", dc_co, 1);
    check_eq("rst_pulse", pulse_out, 0);
    check_eq("rst_data_q", data_q, 0);
    check_eq("rst_dc_cnt", dc_cnt, 0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Detection of 1101 after a leading 0
    det_bits = 5'b01101;
    det_en = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      serin = det_bits[i];
      tick();
      check_eq($sformatf("det_w_%0d", 4 - i), w, (i == 0));
    end
    serin = 1'b1;
    #1;
    check_eq("det_w_no_comb", w, 1);
    det_en = 1'b0;
    tick();
    check_eq("det_w_drop", w, 0);

    // Overlapping patterns
    ovl_bits = 7'b1101101;
    ovl_w    = 7'b0001001;
    det_en = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      serin = ovl_bits[i];
      tick();
      check_eq($sformatf("ovl_w_%0d", 6 - i), w, ovl_w[i]);
    end
    det_en = 1'b0;
    serin = 1'b0;
    tick();

    // Capture 0101 and generate a 5-cycle pulse
    uc_set0 = 1'b1;
    tick();
    uc_set0 = 1'b0;
    capture4(4'b0101, "cap");
    #1;
    check_eq("cap_uc_co_idle", uc_co, 0);
    check_eq("cap_data_q", data_q, 5);
    dc_ld = 1'b1;
    tick();
    dc_ld = 1'b0;
    dc_en = 1'b1;
    check_eq("cnt5_loaded", dc_cnt, 5);
    measure_pulse(20, hi, first_co);
    check_eq("cnt5_pulse_len", hi, 5);
    check_eq("cnt5_dc_co_rise", first_co, 5);
    check_eq("cnt5_end_cnt", dc_cnt, 0);
    dc_en = 1'b0;

    // Zero length
    uc_set0 = 1'b1;
    tick();
    uc_set0 = 1'b0;
    capture4(4'b0000, "zero");
    check_eq("zero_data_q", data_q, 0);
    dc_ld = 1'b1;
    tick();
    dc_ld = 1'b0;
    dc_en = 1'b1;
    check_eq("zero_dc_co", dc_co, 1);
    measure_pulse(6, hi, first_co);
    check_eq("zero_pulse_len", hi, 0);
    check_eq("zero_dc_cnt", dc_cnt, 0);
    dc_en = 1'b0;

    // Clear beats capture; load beats decrement; maximum length
    uc_en = 1'b1;
    serin = 1'b1;
    tick();
    tick();
    check_eq("pri_pre_data_q", data_q, 3);
    uc_set0 = 1'b1;
    tick();
    uc_set0 = 1'b0;
    uc_en = 1'b0;
    check_eq("pri_clear_data_q", data_q, 0);
    capture4(4'b1111, "pri");
    check_eq("pri_data_q", data_q, 15);
    dc_ld = 1'b1;
    dc_en = 1'b1;
    tick();
    dc_ld = 1'b0;
    check_eq("pri_dc_cnt", dc_cnt, 15);
    measure_pulse(30, hi, first_co);
    check_eq("max_pulse_len", hi, 15);
    check_eq("max_dc_co_rise", first_co, 15);
    dc_en = 1'b0;

    // Reset in the middle of a pulse with w high
    dc_ld = 1'b1;
    tick();
    dc_ld = 1'b0;
    dc_en = 1'b1;
    det_en = 1'b1;
    det_bits = 5'b01101;
    for (int i = 3; i >= 0; i--) begin
      serin = det_bits[i];
      tick();
    end
    check_eq("mid_pre_pulse", pulse_out, 1);
    check_eq("mid_pre_w", w, 1);
    check_eq("mid_pre_cnt", dc_cnt, 11);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_pulse", pulse_out, 0);
    check_eq("mid_dc_cnt", dc_cnt, 0);
    check_eq("mid_data_q", data_q, 0);
    check_eq("mid_w", w, 0);
    check_eq("mid_dc_co", dc_co, 1);
    det_en = 1'b0;
    dc_en = 1'b0;
    serin = 1'b0;
    @(negedge clk) rst = 1'b0;
    tick();
    measure_pulse(4, hi, first_co);
    check_eq("post_rst_pulse", hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pulse_len_datapath.md
# pulse_len_datapath

Datapath for the serial pulse-length generator, driven by its controller FSM. It detects the start pattern on `serin`, captures the following `DATA_W` serial bits as a length value, and then counts that value down while driving `pulse_out` high. The block consumes the controller's enables (`det_en`, `uc_en`, `uc_set0`, `dc_en`, `dc_ld`) and returns its status flags (`w`, `uc_co`, `dc_co`).

## Interface
- `PAT`, default 4'b1101: start pattern, MSB received first.
- `PAT_LEN`, default 4: pattern length in bits.
- `DATA_W`, default 4: number of captured data bits; also the down-counter width.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `serin` input 1: serial data, one bit per clock.
- `det_en` input 1: detector enable.
- `uc_en` input 1: up-counter increment and data-capture enable.
- `uc_set0` input 1: synchronous clear of the up counter and the data register.
- `dc_ld` input 1: load the down counter from the data register.
- `dc_en` input 1: down-counter decrement enable.
- `w` output 1: pattern detected.
- `uc_co` output 1: last data bit is being captured this cycle.
- `dc_co` output 1: down counter is zero.
- `pulse_out` output 1: generated pulse.
- `data_q` output DATA_W: captured length value.
- `dc_cnt` output DATA_W: down-counter value.

## Operation
- **Detector**
  - Registers: `hist[PAT_LEN-1:0]` and `fill`, a saturating count from 0 to PAT_LEN.
  - `det_en`=1: `hist <= {hist[PAT_LEN-2:0], serin}` and `fill` increments until it reaches PAT_LEN.
  - `det_en`=0: `hist` and `fill` clear to 0.
  - `w = (fill==PAT_LEN) && (hist==PAT)`.
  - `w` is a Moore output: it depends on registers only and never combinationally on `det_en` or `serin`. This is required because the controller derives `det_en` from `w`.
  - Overlapping patterns are detected.
- **Up counter / capture**
  - `uc_cnt` has width ceil(log2(DATA_W)) and counts 0..DATA_W-1.
  - `uc_set0` has priority: `uc_cnt <= 0` and `data_q <= 0`.
  - Otherwise, when `uc_en`=1:
    - `data_q <= {data_q[DATA_W-2:0], serin}`, so the data is received MSB first.
    - `uc_cnt` increments and wraps from DATA_W-1 to 0.
  - `uc_co = uc_en && (uc_cnt==DATA_W-1)`, combinational.
- **Down counter**
  - `dc_ld` has priority: `dc_cnt <= data_q` and `busy <= 1`.
  - Otherwise, when `dc_en`=1 and `dc_cnt`≠0: `dc_cnt` decrements. It saturates at 0 and never wraps.
  - `busy` clears on the first clock where `dc_cnt==0` and `dc_ld`=0.
  - `dc_co = (dc_cnt==0)`, combinational from the register only, with no dependence on `dc_en`.
  - `pulse_out = busy && (dc_cnt!=0)`.
- **Reset**: all registers are 0, giving `w`=0, `uc_co`=0, `dc_co`=1, `pulse_out`=0, `data_q`=0, `dc_cnt`=0.
- **Reset mid-operation**: all state clears immediately, with no partial pulse afterwards.
- **Simultaneous enables**:
  - `det_en` and `uc_en` act independently.
  - `uc_set0` together with `uc_en`: clear wins and no bit is captured.
  - `dc_ld` together with `dc_en`: load wins.

## Timing
- `w` rises in the cycle after the edge that shifted in the last pattern bit.
- The bit on `serin` during that cycle is data bit 0 (the MSB). The controller asserts `uc_en` in the same cycle, so that bit is captured on that edge.
- Capture takes DATA_W consecutive `uc_en` cycles. `uc_co` is high in the last of them.
- `dc_ld` edge followed by D decrementing cycles: `pulse_out` is high for exactly D cycles, starting the cycle after the load edge. `dc_co` rises in the cycle after the final decrement.
- D=0: `dc_co` is high right after load and `pulse_out` never asserts.
- No combinational path exists from any input to `w` or `dc_co`.

## Test plan
- **Reset mid-pulse**: assert `rst` during `pulse_out`=1 → `pulse_out`, `dc_cnt`, `data_q` and `w` are 0 at once, and `dc_co`=1.
- **Detection**: `det_en`=1, serin 0,1,1,0,1 → `w`=1 only in the cycle after the fifth bit. Then `det_en`=0 → `w`=0 on the next cycle.
- **Overlap**: serin 1,1,0,1,1,0,1 with `det_en` held high → `w` high after bit 4 and again after bit 7.
- **Capture and count**: `uc_set0` pulse, then `uc_en` for 4 cycles with serin 0,1,0,1 → `uc_co` high in the 4th cycle and `data_q`=4'b0101. Then `dc_ld`, then `dc_en` → `pulse_out` high for exactly 5 cycles and `dc_co` rises in the cycle after the last decrement.
- **Zero length**: captured data 0000 and `dc_ld` → `dc_co`=1 the next cycle, `pulse_out` stays 0, and `dc_en` held high leaves `dc_cnt` at 0.
- **Priority and maximum**: `uc_set0` and `uc_en` together → `uc_cnt`=0, `data_q`=0. `dc_ld` and `dc_en` together with `data_q`=15 → `dc_cnt`=15, and the following pulse lasts 15 cycles.
